// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the OBI memory responder.
//   obi_resp_t     - one queued response: read data plus error flag.
//   OBI_ERR_RDATA  - rdata value returned with error responses and for writes.
package core_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_resp_t;

    localparam logic [31:0] OBI_ERR_RDATA = 32'h0;

endpackage

// File: rtl/obi_mem_responder_if.sv
// obi_mem_responder_if: OBI request/response channel between an initiator and
// the memory responder. Signal names keep the responder's point of view
// (_i driven by the initiator, _o driven by the responder).
//   master modport - initiator side: drives req/addr/we/be/wdata/rready.
//   slave modport  - responder side: drives gnt/rvalid/rdata/err.
interface obi_mem_responder_if;

    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic        obi_rvalid_o;
    logic        obi_rready_i;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;

    modport master (
        output obi_req_i,
        output obi_addr_i,
        output obi_we_i,
        output obi_be_i,
        output obi_wdata_i,
        output obi_rready_i,
        input  obi_gnt_o,
        input  obi_rvalid_o,
        input  obi_rdata_o,
        input  obi_err_o
    );

    modport slave (
        input  obi_req_i,
        input  obi_addr_i,
        input  obi_we_i,
        input  obi_be_i,
        input  obi_wdata_i,
        input  obi_rready_i,
        output obi_gnt_o,
        output obi_rvalid_o,
        output obi_rdata_o,
        output obi_err_o
    );

endinterface

// File: rtl/obi_resp_fifo.sv
// obi_resp_fifo: in-order response queue of obi_resp_t entries.
//   clk_i, rst_n_i - clock, asynchronous active-low reset (empties the queue)
//   push_i, push_data_i - enqueue one response at the clock edge
//   pop_i          - retire the head entry at the clock edge
//   head_o         - head entry, all zero when empty
//   full_o, empty_o, count_o - occupancy
module obi_resp_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            push_i,
    input  obi_resp_t       push_data_i,
    input  logic            pop_i,
    output obi_resp_t       head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    obi_resp_t       r_mem [DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (r_count == CntW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign w_pop   = pop_i && !empty_o;
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign w_push  = push_i && (!full_o || w_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    // Storage holds no reset; empty entries are masked at the output.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data_i;
    end

    assign head_o = empty_o ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: word-addressed memory behind an OBI slave port with a
// bounded queue of in-order responses.
//   clk_i   - clock, all state on the rising edge
//   rst_n_i - asynchronous active-low reset; empties the response queue only
//   stall_i - withholds grant while high
//   bus     - OBI slave modport (req/gnt, addr/we/be/wdata, rvalid/rready/rdata/err)
module obi_mem_responder
    import core_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               stall_i,
    obi_mem_responder_if.slave bus
);

    localparam int unsigned AddrW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CntW  = $clog2(RESP_DEPTH + 1);

    logic [31:0]     r_mem [MEM_WORDS];
    logic [31:0]     w_word_idx;
    logic [AddrW-1:0] w_mem_idx;
    logic            w_in_range;
    logic            w_gnt;
    logic            w_accept;
    logic            w_wr_en;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CntW-1:0] w_count;
    obi_resp_t       w_push_resp;
    obi_resp_t       w_head;

    // Byte address bits [1:0] drop out of the word index.
    assign w_word_idx = bus.obi_addr_i >> 2;
    assign w_in_range = (w_word_idx < MEM_WORDS);
    assign w_mem_idx  = w_word_idx[AddrW-1:0];

    // Grant depends only on stall and occupancy, never on rready.
    assign w_gnt    = !stall_i && (w_count < CntW'(RESP_DEPTH));
    assign w_accept = bus.obi_req_i && w_gnt;
    // Writes are suppressed while in reset even though grant follows stall.
    assign w_wr_en  = w_accept && bus.obi_we_i && w_in_range && rst_n_i;
    assign w_pop    = !w_empty && bus.obi_rready_i;

    always_comb begin
        w_push_resp = '0;
        if (!w_in_range) begin
            w_push_resp.rdata = OBI_ERR_RDATA;
            w_push_resp.err   = 1'b1;
        end else if (!bus.obi_we_i) begin
            w_push_resp.rdata = r_mem[w_mem_idx];
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.obi_be_i[k]) r_mem[w_mem_idx][8*k +: 8] <= bus.obi_wdata_i[8*k +: 8];
            end
        end
    end

    obi_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (w_accept),
        .push_data_i (w_push_resp),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    assign bus.obi_gnt_o    = w_gnt;
    assign bus.obi_rvalid_o = !w_empty;
    assign bus.obi_rdata_o  = w_head.rdata;
    assign bus.obi_err_o    = w_head.err;

    // Grant must never be offered into a full queue.
    a_no_gnt_when_full : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        w_full |-> !w_gnt);

endmodule

// File: tb/tb_obi_mem_responder.sv
module tb_obi_mem_responder;

    localparam int MEM_WORDS  = 4096;
    localparam int RESP_DEPTH = 2;
    localparam int AW         = $clog2(MEM_WORDS);

    typedef struct packed {
        logic        rdata_err_unused;
        logic [31:0] rdata;
        logic        err;
    } resp_pad_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rready;
        logic        stall;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    logic stall;

    obi_mem_responder_if bus ();

    obi_mem_responder #(
        .MEM_WORDS  (MEM_WORDS),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .stall_i (stall),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: memory image plus queue of expected responses.
    logic [31:0] model_mem [MEM_WORDS];
    resp_t       exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    logic        o_gnt, o_rvalid, o_err;
    logic [31:0] o_rdata;
    logic [34:0] exp_v, got_v;

    function automatic stim_t mk(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input logic rready, input logic stl);
        stim_t s;
        s.req = req; s.we = we; s.addr = addr; s.be = be;
        s.wdata = wdata; s.rready = rready; s.stall = stl;
        return s;
    endfunction

    // Expected {gnt, rvalid, rdata, err} for the current cycle.
    function automatic logic [34:0] model_obs();
        resp_t h;
        h = '0;
        if (exp_q.size() != 0) h = exp_q[0];
        return {!stall && (exp_q.size() < RESP_DEPTH), exp_q.size() != 0, h.rdata, h.err};
    endfunction

    task automatic drive(input stim_t s);
        bus.obi_req_i    = s.req;
        bus.obi_we_i     = s.we;
        bus.obi_addr_i   = s.addr;
        bus.obi_be_i     = s.be;
        bus.obi_wdata_i  = s.wdata;
        bus.obi_rready_i = s.rready;
        stall            = s.stall;
        @(negedge clk);
        o_gnt    = bus.obi_gnt_o;
        o_rvalid = bus.obi_rvalid_o;
        o_rdata  = bus.obi_rdata_o;
        o_err    = bus.obi_err_o;
        got_v    = {o_gnt, o_rvalid, o_rdata, o_err};
        exp_v    = model_obs();
    endtask

    // Apply the effect of the coming rising edge to the model, then step past it.
    task automatic advance();
        logic        acc, pop;
        logic [31:0] w;
        resp_t       r;
        acc = bus.obi_req_i && !stall && (exp_q.size() < RESP_DEPTH);
        pop = bus.obi_rready_i && (exp_q.size() != 0);
        @(posedge clk);
        if (rst_n) begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                w = bus.obi_addr_i >> 2;
                r = '0;
                if (w >= MEM_WORDS) begin
                    r.err = 1'b1;
                end else if (bus.obi_we_i) begin
                    for (int k = 0; k < 4; k++)
                        if (bus.obi_be_i[k])
                            model_mem[w[AW-1:0]][8*k +: 8] = bus.obi_wdata_i[8*k +: 8];
                end else begin
                    r.rdata = model_mem[w[AW-1:0]];
                end
                exp_q.push_back(r);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, i == 1));
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h want %h (gnt,rvalid,rdata,err)", i, got_v, exp_v);
            end
            n_checks++;
            if (o_gnt !== (i == 0)) begin
                n_fail++;
                $display("FAIL reset_gnt[%0d]: got %b want %b", i, o_gnt, (i == 0));
            end
            advance();
        end
        rst_n = 1'b1;
        drive(mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0));
        n_checks++;
        if (got_v !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", got_v, {1'b1, 1'b0, 32'h0, 1'b0});
        end
        advance();
    endtask

    task automatic test_write_read();
        stim_t rows [4];
        rows[0] = mk(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0);
        rows[1] = mk(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[2] = mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[3] = rows[2];
        for (int i = 0; i < 4; i++) begin
            drive(rows[i]);
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL write_read[%0d]: got %h want %h", i, got_v, exp_v);
            end
            if (i == 2) begin
                n_checks++;
                if ({o_rvalid, o_rdata, o_err} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
                    n_fail++;
                    $display("FAIL write_read_data: got rvalid=%b rdata=%h err=%b want 1 deadbeef 0",
                             o_rvalid, o_rdata, o_err);
                end
            end
            advance();
        end
    endtask

    task automatic test_byte_enable();
        stim_t rows [5];
        rows[0] = mk(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1, 1'b0);
        rows[1] = mk(1'b1, 1'b1, 32'h20, 4'h1, 32'h000000AA, 1'b1, 1'b0);
        rows[2] = mk(1'b1, 1'b0, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0);
        rows[3] = mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[4] = rows[3];
        for (int i = 0; i < 5; i++) begin
            drive(rows[i]);
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL byte_enable[%0d]: got %h want %h", i, got_v, exp_v);
            end
            if (i == 3) begin
                n_checks++;
                if (o_rdata !== 32'h112233AA) begin
                    n_fail++;
                    $display("FAIL byte_enable_data: got %h want 112233aa", o_rdata);
                end
            end
            advance();
        end
    endtask

    task automatic test_out_of_range();
        stim_t rows [6];
        rows[0] = mk(1'b1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0);
        rows[1] = mk(1'b1, 1'b0, 32'h4000, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[2] = mk(1'b1, 1'b1, 32'h4000, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0);
        rows[3] = mk(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[4] = mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[5] = rows[4];
        for (int i = 0; i < 6; i++) begin
            drive(rows[i]);
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL out_of_range[%0d]: got %h want %h", i, got_v, exp_v);
            end
            if (i == 2) begin
                n_checks++;
                if ({o_rvalid, o_rdata, o_err} !== {1'b1, 32'h0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL oor_err: got rvalid=%b rdata=%h err=%b want 1 0 1",
                             o_rvalid, o_rdata, o_err);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (o_rdata !== 32'hCAFEF00D) begin
                    n_fail++;
                    $display("FAIL oor_word0_kept: got %h want cafef00d", o_rdata);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        stim_t rows [8];
        logic  gnt_want [5];
        gnt_want = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rows[0] = mk(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);
        rows[1] = mk(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0);
        rows[2] = mk(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        rows[3] = mk(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[4] = rows[2];
        rows[5] = mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[6] = rows[5];
        rows[7] = rows[5];
        for (int i = 0; i < 8; i++) begin
            drive(rows[i]);
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, got_v, exp_v);
            end
            if (i < 5) begin
                n_checks++;
                if (o_gnt !== gnt_want[i]) begin
                    n_fail++;
                    $display("FAIL b2b_gnt[%0d]: got %b want %b", i, o_gnt, gnt_want[i]);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (o_rdata !== 32'hCAFEF00D) begin
                    n_fail++;
                    $display("FAIL b2b_order: got %h want cafef00d", o_rdata);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        int n_resp = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 4) drive(mk(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, i < 3));
            else       drive(mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0));
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %h want %h", i, got_v, exp_v);
            end
            if (i < 4) begin
                n_checks++;
                if (o_gnt !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL stall_gnt[%0d]: got %b want %b", i, o_gnt, (i == 3));
                end
            end
            if (o_rvalid === 1'b1) n_resp++;
            advance();
        end
        n_checks++;
        if (n_resp != 1) begin
            n_fail++;
            $display("FAIL stall_resp_count: got %0d want 1", n_resp);
        end
    endtask

    task automatic test_random();
        stim_t       s;
        int unsigned sel;
        logic [31:0] a;
        for (int i = 0; i < 332; i++) begin
            if (i < 16) begin
                s = mk(1'b1, 1'b1, 32'h100 + 32'(4 * i), 4'hF, $urandom, 1'b1, 1'b0);
            end else if (i < 316) begin
                sel = $urandom_range(0, 19);
                if (sel < 16)      a = 32'h100 + 32'(4 * sel) + 32'($urandom_range(0, 3));
                else if (sel < 18) a = 32'h4000 + 32'($urandom_range(0, 255));
                else               a = $urandom | 32'h8000_0000;
                s = mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
                       4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 4) == 0);
            end else begin
                s = mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
            end
            drive(s);
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, got_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        stim_t rows [6];
        rows[0] = mk(1'b1, 1'b1, 32'h30, 4'hF, 32'h5A5A1234, 1'b0, 1'b0);
        rows[1] = mk(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, 1'b0, 1'b0);
        rows[2] = mk(1'b1, 1'b1, 32'h30, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0);
        rows[3] = mk(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[4] = mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        rows[5] = rows[4];
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                rst_n = 1'b0;
                #1;
                exp_q.delete();
                n_checks++;
                if ({bus.obi_rvalid_o, bus.obi_rdata_o, bus.obi_err_o} !== 34'h0) begin
                    n_fail++;
                    $display("FAIL reset_async: got rvalid=%b rdata=%h err=%b want 0 0 0",
                             bus.obi_rvalid_o, bus.obi_rdata_o, bus.obi_err_o);
                end
            end
            if (i == 3) rst_n = 1'b1;
            drive(rows[i]);
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got %h want %h", i, got_v, exp_v);
            end
            if (i == 4) begin
                n_checks++;
                if ({o_rvalid, o_rdata} !== {1'b1, 32'h5A5A1234}) begin
                    n_fail++;
                    $display("FAIL reset_mem_kept: got rvalid=%b rdata=%h want 1 5a5a1234",
                             o_rvalid, o_rdata);
                end
            end
            advance();
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        stall            = 1'b0;
        bus.obi_req_i    = 1'b0;
        bus.obi_we_i     = 1'b0;
        bus.obi_addr_i   = 32'h0;
        bus.obi_be_i     = 4'h0;
        bus.obi_wdata_i  = 32'h0;
        bus.obi_rready_i = 1'b0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_out_of_range();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
